sram_port_arbiter: RTL
======================

# sram_port_arbiter

Two-port arbiter that shares the single 32-bit SRAM controller between the LSU data port (port 0) and a second master (port 1, instruction fetch or DMA). Accepts level requests, grants round-robin, holds one command stable on the controller until its ACK, then returns a one-cycle response pulse to the winner. Sits between the masters and the SRAM controller, replacing direct LSU drive of the controller's WREN/RDEN.

## Interface
- `TIMEOUT_CYC`, default 64: cycles in BUSY without controller ACK before abort (only with `SRAM_ARB_TIMEOUT_EN`).
- `i_clk` in 1: clock, all state on rising edge.
- `i_rst` in 1: reset, asynchronous, active-low.
- `i_m0_req`, `i_m1_req` in 1: request, level, held until that port's ack.
- `i_m0_we`, `i_m1_we` in 1: 1 = write, 0 = read.
- `i_m0_addr`, `i_m1_addr` in 32: byte address.
- `i_m0_wdata`, `i_m1_wdata` in 32: store data.
- `i_m0_bmask`, `i_m1_bmask` in 4: byte enables.
- `o_m0_ack`, `o_m1_ack` out 1: one-cycle completion pulse.
- `o_m0_rdata`, `o_m1_rdata` out 32: read data, valid when ack is high.
- `o_m0_err`, `o_m1_err` out 1: timeout flag, qualified by ack.
- `o_sram_addr` out 32, `o_sram_wdata` out 32, `o_sram_bmask` out 4: latched command.
- `o_sram_wren`, `o_sram_rden` out 1: controller strobes, held until ACK.
- `i_sram_ack` in 1: controller completion.
- `i_sram_rdata` in 32: controller read data.
- `o_busy` out 1: high in BUSY or RESP.

## Operation
- States: IDLE, BUSY, RESP.
  - Reset: state IDLE, `last_grant` = 1, all outputs 0.
- IDLE:
  - If any req is high, choose a winner and latch its we/addr/wdata/bmask into the command registers.
  - Store the winner in `gnt`, then go to BUSY.
  - With no request, stay in IDLE.
- Arbitration:
  - A single requester wins.
  - When both request, the port not equal to `last_grant` wins.
  - `last_grant` is updated to `gnt` on entry to RESP.
- BUSY:
  - Exactly one of `o_sram_wren`/`o_sram_rden` is high, chosen by the latched we.
  - Command outputs stay constant.
  - Master inputs are ignored; changes have no effect.
  - On `i_sram_ack`: register `i_sram_rdata`, then go to RESP.
- RESP:
  - Strobes are 0.
  - `o_m<gnt>_ack` = 1 and `o_m<gnt>_rdata` = registered data; the other port's ack stays 0.
  - Unconditionally go to IDLE.
- Data outputs:
  - rdata holds its value after the ack pulse.
  - For a write, rdata is the controller rdata as sampled; it carries no meaning.
- Stray `i_sram_ack` in IDLE or RESP: ignored, no state change.
- Reset asserted mid-operation: immediate return to IDLE, strobes to 0 asynchronously, no ack issued. The in-flight master must reissue.

## Timing
- Req high in IDLE at cycle T:
  - Strobe is high from T+1.
  - If ack is sampled at cycle K, RESP is at K+1 and IDLE at K+2.
- Minimum latency, req to master ack:
  - 2 cycles when the controller acks in the first BUSY cycle.
  - K−T+1 cycles in general.
- Masters must deassert req in the cycle after their ack (K+2). A req still high in IDLE at K+2 is a new request.
- Back-to-back contending requests alternate grants with one IDLE cycle between transactions.
- Command registers change only on the IDLE→BUSY edge.

## Configuration
- `SRAM_ARB_TIMEOUT_EN` defined:
  - An up-counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When it reaches `TIMEOUT_CYC` − 1 without ack, go to RESP with `o_m<gnt>_err` = 1 and rdata = 32'h0.
  - Strobes drop in RESP as usual.
  - A late controller ack is ignored as stray.
  - An ack in the same cycle as the timeout threshold takes priority: normal completion, err = 0.
- Not defined:
  - No counter; BUSY waits indefinitely.
  - `o_m0_err`/`o_m1_err` are constant 0.
  - `TIMEOUT_CYC` is unused.

## Test plan
- Port 0 read of 0x2004, controller acks 3 cycles after rden rises with rdata 0x12345678 → `o_m0_ack` pulses once with rdata 0x12345678; `o_m1_ack` stays 0; rden high exactly 4 cycles.
- Both ports request from reset, both writes, ack 1 cycle after the strobe → m0 is granted first, then m1. wdata/bmask/addr on the controller match each port, with one IDLE cycle between.
- Both ports hold continuous requests for 6 transactions → grants alternate 0,1,0,1,0,1; no port is starved.
- Port 1 changes addr while BUSY → `o_sram_addr` is unchanged until the next grant.
- Reset pulled low during BUSY → strobes drop the same cycle, no ack; after release a new port 0 request completes normally.
- With `SRAM_ARB_TIMEOUT_EN` and `TIMEOUT_CYC` = 8, controller never acks → ack and err pulse together 8 cycles after entering BUSY with rdata 0; a later stray ack causes no response.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: round-robin two-master front end for the single SRAM
// controller. Port 0 is the LSU, port 1 is fetch/DMA. One command is held on
// the controller until its ACK, then a one-cycle response goes to the winner.
// Optional feature macro: SRAM_ARB_TIMEOUT_EN (aborts BUSY after TIMEOUT_CYC
// cycles without ACK and flags err on the response).
module sram_port_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_m0_req,
  input  logic        i_m1_req,
  input  logic        i_m0_we,
  input  logic        i_m1_we,
  input  logic [31:0] i_m0_addr,
  input  logic [31:0] i_m1_addr,
  input  logic [31:0] i_m0_wdata,
  input  logic [31:0] i_m1_wdata,
  input  logic [3:0]  i_m0_bmask,
  input  logic [3:0]  i_m1_bmask,
  output logic        o_m0_ack,
  output logic        o_m1_ack,
  output logic [31:0] o_m0_rdata,
  output logic [31:0] o_m1_rdata,
  output logic        o_m0_err,
  output logic        o_m1_err,
  output logic [31:0] o_sram_addr,
  output logic [31:0] o_sram_wdata,
  output logic [3:0]  o_sram_bmask,
  output logic        o_sram_wren,
  output logic        o_sram_rden,
  input  logic        i_sram_ack,
  input  logic [31:0] i_sram_rdata,
  output logic        o_busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       gnt;
  logic       last_grant;
  logic       we_q;
  logic       any_req;
  logic       win;
  logic       timeout;

  assign any_req = i_m0_req | i_m1_req;

  // Winner selection: lone requester wins, contention goes to the port
  // that was not served last.
  always_comb begin
    win = 1'b0;
    if (i_m0_req && i_m1_req) begin
      win = ~last_grant;
    end else begin
      win = i_m1_req;
    end
  end

`ifdef SRAM_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYC) + 1;

  logic [CW-1:0] cnt;
  logic          err_q;

  assign timeout = (state == ST_BUSY) && !i_sram_ack &&
                   (cnt == CW'(TIMEOUT_CYC - 1));

  // BUSY-cycle counter; held at zero outside BUSY so each grant starts fresh.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt <= '0;
    end else if (state == ST_BUSY) begin
      cnt <= cnt + CW'(1);
    end else begin
      cnt <= '0;
    end
  end

  // Error flag for the current response; an ACK on the threshold cycle wins.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      err_q <= 1'b0;
    end else if (state == ST_BUSY) begin
      err_q <= timeout;
    end
  end

  assign o_m0_err = o_m0_ack & err_q;
  assign o_m1_err = o_m1_ack & err_q;
`else
  assign timeout  = 1'b0;
  assign o_m0_err = 1'b0;
  assign o_m1_err = 1'b0;
`endif

  // Next-state logic for the IDLE -> BUSY -> RESP -> IDLE cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (any_req) state_nxt = ST_BUSY;
      ST_BUSY: if (i_sram_ack || timeout) state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register; async reset drops the strobes immediately.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Grant and command capture, only on the IDLE -> BUSY edge.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      gnt          <= 1'b0;
      we_q         <= 1'b0;
      o_sram_addr  <= '0;
      o_sram_wdata <= '0;
      o_sram_bmask <= '0;
    end else if (state == ST_IDLE && any_req) begin
      gnt          <= win;
      we_q         <= win ? i_m1_we    : i_m0_we;
      o_sram_addr  <= win ? i_m1_addr  : i_m0_addr;
      o_sram_wdata <= win ? i_m1_wdata : i_m0_wdata;
      o_sram_bmask <= win ? i_m1_bmask : i_m0_bmask;
    end
  end

  // Response data per port, loaded when BUSY ends; held afterwards so each
  // master sees its own last result.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_m0_rdata <= '0;
      o_m1_rdata <= '0;
      last_grant <= 1'b1;
    end else if (state == ST_BUSY && (i_sram_ack || timeout)) begin
      last_grant <= gnt;
      if (gnt) begin
        o_m1_rdata <= i_sram_ack ? i_sram_rdata : '0;
      end else begin
        o_m0_rdata <= i_sram_ack ? i_sram_rdata : '0;
      end
    end
  end

  assign o_sram_wren = (state == ST_BUSY) &  we_q;
  assign o_sram_rden = (state == ST_BUSY) & ~we_q;
  assign o_m0_ack    = (state == ST_RESP) & ~gnt;
  assign o_m1_ack    = (state == ST_RESP) &  gnt;
  assign o_busy      = (state != ST_IDLE);

endmodule
